// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV32IM/RV64 immediate generator for the decode
// stage. The immediate is decoded combinationally from INST/IMM_SEL and
// carried to the ID/EX boundary through an output register backed by a
// single-entry skid register (valid/ready, strictly FIFO).
//
// Ports:
//   CLK, RESET_N     clock, asynchronous active-low reset
//   FLUSH            synchronous kill of all held entries
//   IN_VALID/READY   input handshake (IN_READY = !skid_valid)
//   INST, IMM_SEL    raw instruction, immediate select ([3] = unsigned)
//   IN_TAG           side-band tag travelling with the entry
//   OUT_VALID/READY  output handshake
//   IMM_EXT          extended immediate (XLEN bits)
//   OUT_TAG          tag of the output entry
//   OUT_SEL_ILLEGAL  output entry used the unsupported select 7
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 8
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             FLUSH,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [31:0]      INST,
    input  logic [3:0]       IMM_SEL,
    input  logic [TAG_W-1:0] IN_TAG,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [XLEN-1:0]  IMM_EXT,
    output logic [TAG_W-1:0] OUT_TAG,
    output logic             OUT_SEL_ILLEGAL
);

    // State encoding is {skid_valid, out_valid}; 2'b10 is unreachable.
    localparam logic [1:0] S_EMPTY = 2'b00;
    localparam logic [1:0] S_ONE   = 2'b01;
    localparam logic [1:0] S_FULL  = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [XLEN-1:0]  out_imm_q, out_imm_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             out_ill_q, out_ill_d;
    logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
    logic             skid_ill_q, skid_ill_d;

    logic [XLEN-1:0]  imm_c;
    logic             ill_c;
    logic [5:0]       shamt_c;
    logic             accept_c;
    logic             drain_c;
    logic             unused_inst_c;

    // Opcode bits never contribute to an immediate.
    assign unused_inst_c = ^INST[6:0];

    // RV64 shift amounts use one more instruction bit than RV32.
    assign shamt_c = (XLEN == 64) ? INST[25:20] : {1'b0, INST[24:20]};

    // Immediate decode.
    always_comb begin
        imm_c = '0;
        ill_c = 1'b0;
        case (IMM_SEL[2:0])
            3'd0: imm_c = XLEN'($signed({INST[31:12], 12'b0}));
            3'd1: begin
                if (IMM_SEL[3]) begin
                    imm_c = XLEN'({INST[31:12], 1'b0});
                end else begin
                    imm_c = XLEN'($signed({INST[31], INST[19:12], INST[20],
                                           INST[30:21], 1'b0}));
                end
            end
            3'd2: begin
                if (IMM_SEL[3]) begin
                    imm_c = XLEN'(INST[31:20]);
                end else begin
                    imm_c = XLEN'($signed(INST[31:20]));
                end
            end
            3'd3: imm_c = XLEN'($signed({INST[31], INST[7], INST[30:25],
                                         INST[11:8], 1'b0}));
            3'd4: begin
                if (IMM_SEL[3]) begin
                    imm_c = XLEN'({INST[31:25], INST[11:7]});
                end else begin
                    imm_c = XLEN'($signed({INST[31:25], INST[11:7]}));
                end
            end
            3'd5: imm_c = XLEN'(shamt_c);
            3'd6: imm_c = XLEN'(INST[19:15]);
            default: begin
                imm_c = '0;
                ill_c = 1'b1;
            end
        endcase
    end

    assign accept_c = IN_VALID && !state_q[1];
    assign drain_c  = state_q[0] && OUT_READY;

    // Next-state and datapath steering for the output/skid pair.
    always_comb begin
        state_d    = state_q;
        out_imm_d  = out_imm_q;
        out_tag_d  = out_tag_q;
        out_ill_d  = out_ill_q;
        skid_imm_d = skid_imm_q;
        skid_tag_d = skid_tag_q;
        skid_ill_d = skid_ill_q;
        if (FLUSH) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept_c) begin
                        out_imm_d = imm_c;
                        out_tag_d = IN_TAG;
                        out_ill_d = ill_c;
                        state_d   = S_ONE;
                    end
                end
                S_ONE: begin
                    if (accept_c && drain_c) begin
                        out_imm_d = imm_c;
                        out_tag_d = IN_TAG;
                        out_ill_d = ill_c;
                    end else if (accept_c) begin
                        skid_imm_d = imm_c;
                        skid_tag_d = IN_TAG;
                        skid_ill_d = ill_c;
                        state_d    = S_FULL;
                    end else if (drain_c) begin
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (drain_c) begin
                        out_imm_d = skid_imm_q;
                        out_tag_d = skid_tag_q;
                        out_ill_d = skid_ill_q;
                        state_d   = S_ONE;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    // State and payload registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_EMPTY;
            out_imm_q  <= '0;
            out_tag_q  <= '0;
            out_ill_q  <= 1'b0;
            skid_imm_q <= '0;
            skid_tag_q <= '0;
            skid_ill_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_imm_q  <= out_imm_d;
            out_tag_q  <= out_tag_d;
            out_ill_q  <= out_ill_d;
            skid_imm_q <= skid_imm_d;
            skid_tag_q <= skid_tag_d;
            skid_ill_q <= skid_ill_d;
        end
    end

    assign IN_READY        = !state_q[1];
    assign OUT_VALID       = state_q[0];
    assign IMM_EXT         = out_imm_q;
    assign OUT_TAG         = out_tag_q;
    assign OUT_SEL_ILLEGAL = out_ill_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: drives one XLEN=32 and one XLEN=64 instance with the same
// stimulus; expected results are queued at accept time and popped by a
// per-instance monitor whenever an output entry is consumed.
module tb_imm_gen_pipe;

    localparam int unsigned TAG_W = 8;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [63:0]      imm;
        logic             ill;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic [31:0]      inst;
    logic [3:0]       imm_sel;
    logic [TAG_W-1:0] in_tag;
    logic             out_ready;

    logic             in_ready32, out_valid32, ill32;
    logic [31:0]      imm32;
    logic [TAG_W-1:0] tag32;
    logic             in_ready64, out_valid64, ill64;
    logic [63:0]      imm64;
    logic [TAG_W-1:0] tag64;

    exp_t q32[$];
    exp_t q64[$];
    exp_t m32;
    exp_t m64;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
        .CLK(clk), .RESET_N(rst_n), .FLUSH(flush), .IN_VALID(in_valid),
        .IN_READY(in_ready32), .INST(inst), .IMM_SEL(imm_sel), .IN_TAG(in_tag),
        .OUT_VALID(out_valid32), .OUT_READY(out_ready), .IMM_EXT(imm32),
        .OUT_TAG(tag32), .OUT_SEL_ILLEGAL(ill32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
        .CLK(clk), .RESET_N(rst_n), .FLUSH(flush), .IN_VALID(in_valid),
        .IN_READY(in_ready64), .INST(inst), .IMM_SEL(imm_sel), .IN_TAG(in_tag),
        .OUT_VALID(out_valid64), .OUT_READY(out_ready), .IMM_EXT(imm64),
        .OUT_TAG(tag64), .OUT_SEL_ILLEGAL(ill64)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitors: compare every consumed output entry against the queue head.
    always @(negedge clk) begin
        if (rst_n && out_valid32 && out_ready) begin
            if (q32.size() == 0) begin
                chk("mon32 unexpected entry tag", 64'(tag32), 64'hDEAD);
            end else begin
                m32 = q32.pop_front();
                chk("mon32 tag", 64'(tag32), 64'(m32.tag));
                chk("mon32 imm", 64'(imm32), m32.imm);
                chk("mon32 ill", 64'(ill32), 64'(m32.ill));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid64 && out_ready) begin
            if (q64.size() == 0) begin
                chk("mon64 unexpected entry tag", 64'(tag64), 64'hDEAD);
            end else begin
                m64 = q64.pop_front();
                chk("mon64 tag", 64'(tag64), 64'(m64.tag));
                chk("mon64 imm", imm64, m64.imm);
                chk("mon64 ill", 64'(ill64), 64'(m64.ill));
            end
        end
    end

    task automatic push(input logic [TAG_W-1:0] tg, input logic [31:0] e32,
                        input logic [63:0] e64, input logic il);
        exp_t a;
        exp_t b;
        a.tag = tg; a.imm = {32'b0, e32}; a.ill = il;
        b.tag = tg; b.imm = e64;          b.ill = il;
        q32.push_back(a);
        q64.push_back(b);
    endtask

    // Offer one entry and hold it until accepted (bounded).
    task automatic send(input logic [TAG_W-1:0] tg, input logic [31:0] ins,
                        input logic [3:0] sel, input logic [31:0] e32,
                        input logic [63:0] e64, input logic il);
        bit acc = 1'b0;
        inst = ins; imm_sel = sel; in_tag = tg; in_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (in_ready32) begin
                push(tg, e32, e64, il);
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
            if (acc) break;
        end
        in_valid = 1'b0;
        if (!acc) chk("send accept timeout", 64'(0), 64'(1));
    endtask

    // Let the consumer drain everything outstanding (bounded).
    task automatic drain_wait();
        out_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (q32.size() == 0 && q64.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk("drain queues empty", 64'(q32.size() + q64.size()), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pushed;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; inst = '0;
        imm_sel = '0; in_tag = '0; out_ready = 1'b1;
        #12;
        chk("reset out_valid32", 64'(out_valid32), 64'(0));
        chk("reset imm32", 64'(imm32), 64'(0));
        chk("reset in_ready32", 64'(in_ready32), 64'(1));
        chk("reset imm64", imm64, 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // One-cycle latency from EMPTY.
        send(8'h10, 32'hFFF00093, 4'h2, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        chk("latency out_valid32", 64'(out_valid32), 64'(1));
        chk("latency imm32", 64'(imm32), 64'hFFFFFFFF);
        chk("latency tag64", 64'(tag64), 64'h10);

        // Back-to-back directed vectors at full throughput.
        send(8'h11, 32'hFFF00093, 4'hA, 32'h00000FFF, 64'h0000000000000FFF, 1'b0);
        send(8'h12, 32'hFE000EE3, 4'h3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        send(8'h13, 32'hFE000EE3, 4'hB, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        send(8'h14, 32'hFE000EE3, 4'h7, 32'h00000000, 64'h0, 1'b1);
        send(8'h15, 32'h340FD073, 4'h6, 32'h0000001F, 64'h1F, 1'b0);
        send(8'h16, 32'h800000B7, 4'h0, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0);
        send(8'h17, 32'h03F0D093, 4'h5, 32'h0000001F, 64'h3F, 1'b0);
        send(8'h18, 32'h03F0D093, 4'hD, 32'h0000001F, 64'h3F, 1'b0);
        send(8'h19, 32'hFFDFF06F, 4'h1, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        send(8'h1A, 32'hFFDFF06F, 4'h9, 32'h001FFBFE, 64'h1FFBFE, 1'b0);
        send(8'h1B, 32'hFE112C23, 4'h4, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0);
        send(8'h1C, 32'hFE112C23, 4'hC, 32'h00000FF8, 64'hFF8, 1'b0);
        send(8'h1D, 32'h12345037, 4'h0, 32'h12345000, 64'h12345000, 1'b0);
        send(8'h1E, 32'h340FD073, 4'hF, 32'h00000000, 64'h0, 1'b1);
        drain_wait();

        // Back-pressure: tags 1 and 2 fill the block, tag 3 waits.
        out_ready = 1'b0;
        send(8'h01, 32'h12345037, 4'h0, 32'h12345000, 64'h12345000, 1'b0);
        send(8'h02, 32'hFE112C23, 4'h4, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0);
        chk("bp in_ready32 low when full", 64'(in_ready32), 64'(0));
        chk("bp in_ready64 low when full", 64'(in_ready64), 64'(0));
        chk("bp held tag", 64'(tag32), 64'h01);
        inst = 32'hFFDFF06F; imm_sel = 4'h1; in_tag = 8'h03; in_valid = 1'b1;
        out_ready = 1'b1;
        pushed = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp order tag", out_valid32 ? 64'(tag32) : 64'hFF, 64'(k + 1));
            if (!pushed && in_ready32) begin
                push(8'h03, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
                pushed = 1'b1;
            end
            @(posedge clk);
            #1;
            if (pushed) in_valid = 1'b0;
        end
        chk("bp tag3 accepted", 64'(pushed), 64'(1));
        in_valid = 1'b0;
        drain_wait();

        // Flush while FULL with an entry offered.
        out_ready = 1'b0;
        send(8'h21, 32'hFFF00093, 4'h2, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        send(8'h22, 32'hFFF00093, 4'hA, 32'h00000FFF, 64'hFFF, 1'b0);
        flush = 1'b1; in_valid = 1'b1; in_tag = 8'h55; inst = 32'h12345037; imm_sel = 4'h0;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        q32.delete();
        q64.delete();
        chk("flush full out_valid32", 64'(out_valid32), 64'(0));
        chk("flush full out_valid64", 64'(out_valid64), 64'(0));
        chk("flush full in_ready32", 64'(in_ready32), 64'(1));

        // Flush while ONE: the offered entry is dropped though IN_READY=1.
        send(8'h23, 32'h800000B7, 4'h0, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0);
        flush = 1'b1; in_valid = 1'b1; in_tag = 8'h66; inst = 32'h12345037; imm_sel = 4'h0;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        q32.delete();
        q64.delete();
        chk("flush one out_valid32", 64'(out_valid32), 64'(0));
        out_ready = 1'b1;
        send(8'h24, 32'h03F0D093, 4'h5, 32'h0000001F, 64'h3F, 1'b0);
        drain_wait();

        // Asynchronous reset mid-cycle while FULL.
        out_ready = 1'b0;
        send(8'h31, 32'hFE000EE3, 4'h3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        send(8'h32, 32'hFFF00093, 4'h2, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        chk("pre-reset full in_ready32", 64'(in_ready32), 64'(0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid32", 64'(out_valid32), 64'(0));
        chk("async rst imm32", 64'(imm32), 64'(0));
        chk("async rst tag32", 64'(tag32), 64'(0));
        chk("async rst imm64", imm64, 64'(0));
        chk("async rst in_ready32", 64'(in_ready32), 64'(1));
        q32.delete();
        q64.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(8'h33, 32'h340FD073, 4'h6, 32'h0000001F, 64'h1F, 1'b0);
        chk("post-reset latency tag32", 64'(tag32), 64'h33);
        drain_wait();

        repeat (3) @(posedge clk);
        #1;
        chk("final q32 empty", 64'(q32.size()), 64'(0));
        chk("final out_valid32 idle", 64'(out_valid32), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
